// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, FSM encoding
// and the decode helper used by both the control path and the stall logic.
package mdu_defs;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;

    // Ops that occupy the unit for more than one cycle and therefore stall.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Unsigned restoring divider: one shift-subtract step per cycle while step is high.
// A zero divisor yields an all-ones quotient and the dividend as remainder.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
        end else if (step) begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU, WIDTH-cycle DIV/DIVU,
// MTHI/MTLO writes, and the pipeline stall while a multi-cycle op is in flight.
module hilo_muldiv_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_is_div;
    logic               w_op_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept    = (r_state == ST_IDLE) && start_i && !flush_i && is_muldiv(op_i);
    assign w_is_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign w_op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign w_a_neg     = w_op_signed && a_i[WIDTH-1];
    assign w_b_neg     = w_op_signed && b_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (~a_i + 1'b1) : a_i;
    assign w_b_mag     = w_b_neg ? (~b_i + 1'b1) : b_i;

    // One 2W x 2W multiplier serves both forms; the extension bit selects signedness.
    assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept && w_is_div),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .step      (r_state == ST_DIV),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Zero divisor bypasses sign correction so LO stays all ones.
    assign w_quo_fix = (r_q_neg && !r_b_zero) ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_fix = (r_r_neg && !r_b_zero) ? (~w_rem + 1'b1) : w_rem;

    always_comb begin
        w_state_nx = r_state;
        if (flush_i) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nx = w_is_div ? ST_DIV : ST_MUL;
                ST_MUL:  w_state_nx = ST_DONE;
                ST_DIV:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nx = ST_FIX;
                ST_FIX:  w_state_nx = ST_DONE;
                ST_DONE: w_state_nx = ST_IDLE;
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == ST_MUL) || (w_state_nx == ST_DIV) ||
                       (w_state_nx == ST_FIX);
            r_done  <= (w_state_nx == ST_DONE);
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == ST_DIV)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_signed <= w_op_signed;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            r_b_zero <= (b_i == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i && op_i == MDU_MTHI) r_hi <= a_i;
                    if (start_i && op_i == MDU_MTLO) r_lo <= a_i;
                end
                ST_MUL: {r_hi, r_lo} <= w_prod;
                ST_FIX: begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign stall_o = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV) ||
                     (r_state == ST_FIX);
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: multiply/divide results, latency,
// divide boundaries, MTHI/MTLO, flush and reset behaviour.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [2:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         flush_i;
    logic         stall_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_total = 0;
    int n_pass  = 0;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issue an op, hold it while stalled, and check stall length, done pulse and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_stall,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
            a_i = ~a;
            b_i = ~b;
        end
        start_i = 1'b0;
        check({tag, "_stall"}, 64'(n), 64'(exp_stall));
        check({tag, "_done"},  64'(done_o), 64'd1);
        check({tag, "_hi"},    64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"},    64'(lo_o), 64'(exp_lo));
        tick();
        check({tag, "_done_clr"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0; flush_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_hi",    64'(hi_o), 64'd0);
        check("rst_lo",    64'(lo_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(done_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        tick();

        run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3,        2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd4, 32'd100,       32'd7,        34, 32'd2,         32'd14);
        run_op("div0",  3'd4, 32'h0000_1234, 32'd0,        34, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("dovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0,        32'h8000_0000);

        // Busy is registered and high only while the op runs.
        start_i = 1'b1; op_i = 3'd1; a_i = 32'd6; b_i = 32'd7;
        tick();
        check("mul_busy", 64'(busy_o), 64'd1);
        tick();
        start_i = 1'b0;
        check("mul_busy_done", 64'(busy_o), 64'd0);
        check("mul_small_lo", 64'(lo_o), 64'd42);
        tick();

        start_i = 1'b1; op_i = 3'd5; a_i = 32'hAAAA_5555;
        #1;
        check("mthi_stall", 64'(stall_o), 64'd0);
        tick();
        check("mthi_hi", 64'(hi_o), 64'hAAAA_5555);
        check("mthi_lo_keep", 64'(lo_o), 64'd42);
        op_i = 3'd6; a_i = 32'h1234_5678;
        #1;
        check("mtlo_stall", 64'(stall_o), 64'd0);
        tick();
        check("mtlo_lo", 64'(lo_o), 64'h1234_5678);
        check("mtlo_hi_keep", 64'(hi_o), 64'hAAAA_5555);

        // NONE and the unused code 7 have no effect.
        op_i = 3'd0; a_i = 32'hDEAD_BEEF;
        #1;
        check("none_stall", 64'(stall_o), 64'd0);
        tick();
        op_i = 3'd7;
        #1;
        check("op7_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0;
        check("none_hilo", {hi_o, lo_o}, {32'hAAAA_5555, 32'h1234_5678});
        check("none_busy", 64'(busy_o), 64'd0);

        // Flush in IDLE overrides start.
        start_i = 1'b1; op_i = 3'd5; a_i = 32'h0BAD_0BAD; flush_i = 1'b1;
        #1;
        check("flush_idle_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_idle_hi", 64'(hi_o), 64'hAAAA_5555);

        // Flush on the 10th DIV cycle.
        start_i = 1'b1; op_i = 3'd3; a_i = 32'd50; b_i = 32'd5;
        tick();
        for (int i = 0; i < 9; i++) tick();
        check("flush_div_stall", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        check("flush_div_state", {61'd0, stall_o, busy_o, done_o}, 64'd0);
        check("flush_div_hilo", {hi_o, lo_o}, {32'hAAAA_5555, 32'h1234_5678});
        begin
            int seen_done = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (done_o) seen_done++;
            end
            check("flush_div_nodone", 64'(seen_done), 64'd0);
        end

        // Reset mid-division clears HI/LO.
        start_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
        for (int i = 0; i < 6; i++) tick();
        start_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_div_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_div_stall", 64'(stall_o), 64'd0);
        check("rst_div_busy", 64'(busy_o), 64'd0);
        tick();

        run_op("divu_after_rst", 3'd4, 32'd1000, 32'd3, 34, 32'd1, 32'd333);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
